// File: rtl/uart_rx_fifo.sv
// Receive-side byte buffer behind the UART de-serializer. It edge-detects the byte-ready strobe,
// stores each byte in a first-word-fall-through FIFO, and counts bytes lost to overflow.
module uart_rx_fifo #(
  parameter int unsigned DEPTH_LOG2   = 4,
  parameter int unsigned AFULL_MARGIN = 2
) (
  input  logic                  sys_clk,
  input  logic                  sys_rst,
  input  logic [7:0]            rx_data,
  input  logic                  rx_ready,
  input  logic                  rd_en,
  input  logic                  clr_overflow,
  output logic [7:0]            rd_data,
  output logic                  empty,
  output logic                  full,
  output logic                  almost_full,
  output logic                  rx_cts_ok,
  output logic [DEPTH_LOG2:0]   count,
  output logic                  overflow,
  output logic [7:0]            drop_cnt
);

  localparam int unsigned Depth = 2 ** DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] CntFull  = (DEPTH_LOG2 + 1)'(Depth);
  localparam logic [DEPTH_LOG2:0] CntAfull = (DEPTH_LOG2 + 1)'(Depth - AFULL_MARGIN);

  logic [7:0]            r_mem [Depth];
  logic [DEPTH_LOG2-1:0] r_wr_ptr;
  logic [DEPTH_LOG2-1:0] r_rd_ptr;
  logic [DEPTH_LOG2:0]   r_count;
  logic                  r_full;
  logic                  r_afull;
  logic                  r_rx_ready_q;
  logic                  r_overflow;
  logic [7:0]            r_drop_cnt;

  logic                  w_wr;
  logic                  w_rd;
  logic                  w_push;
  logic                  w_drop;
  logic [DEPTH_LOG2:0]   w_count_d;

  always_comb begin
    w_wr      = rx_ready & ~r_rx_ready_q;
    w_rd      = rd_en & (r_count != '0);
    // A pop in the same cycle frees the slot, so a write at full is still accepted.
    w_push    = w_wr & (~r_full | w_rd);
    w_drop    = w_wr & r_full & ~w_rd;
    w_count_d = r_count;
    unique case ({w_push, w_rd})
      2'b10:   w_count_d = r_count + 1'b1;
      2'b01:   w_count_d = r_count - 1'b1;
      default: w_count_d = r_count;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_count      <= '0;
      r_full       <= 1'b0;
      r_afull      <= 1'b0;
      r_rx_ready_q <= 1'b1;
      r_overflow   <= 1'b0;
      r_drop_cnt   <= '0;
    end else begin
      r_rx_ready_q <= rx_ready;
      r_count      <= w_count_d;
      r_full       <= (w_count_d == CntFull);
      r_afull      <= (w_count_d >= CntAfull);
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_rd) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      if (w_drop) begin
        r_overflow <= 1'b1;
      end else if (clr_overflow) begin
        r_overflow <= 1'b0;
      end
      if (w_drop && (r_drop_cnt != 8'hFF)) begin
        r_drop_cnt <= r_drop_cnt + 1'b1;
      end
    end
  end

  // Storage is deliberately left out of reset.
  always_ff @(posedge sys_clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= rx_data;
    end
  end

  always_comb begin
    rd_data     = r_mem[r_rd_ptr];
    empty       = (r_count == '0);
    full        = r_full;
    almost_full = r_afull;
    rx_cts_ok   = ~r_afull;
    count       = r_count;
    overflow    = r_overflow;
    drop_cnt    = r_drop_cnt;
  end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo: directed scenarios followed by random traffic, all compared every cycle
// against a queue-based model of the buffer.
module tb_uart_rx_fifo;

  localparam int Depth  = 16;
  localparam int Margin = 2;

  logic       sys_clk = 1'b0;
  logic       sys_rst;
  logic [7:0] rx_data;
  logic       rx_ready;
  logic       rd_en;
  logic       clr_overflow;
  logic [7:0] rd_data;
  logic       empty;
  logic       full;
  logic       almost_full;
  logic       rx_cts_ok;
  logic [4:0] count;
  logic       overflow;
  logic [7:0] drop_cnt;

  int checks   = 0;
  int failures = 0;

  byte unsigned m_q[$];
  bit           m_prev;
  bit           m_ovf;
  int           m_drop;

  uart_rx_fifo #(
    .DEPTH_LOG2  (4),
    .AFULL_MARGIN(2)
  ) dut (
    .sys_clk     (sys_clk),
    .sys_rst     (sys_rst),
    .rx_data     (rx_data),
    .rx_ready    (rx_ready),
    .rd_en       (rd_en),
    .clr_overflow(clr_overflow),
    .rd_data     (rd_data),
    .empty       (empty),
    .full        (full),
    .almost_full (almost_full),
    .rx_cts_ok   (rx_cts_ok),
    .count       (count),
    .overflow    (overflow),
    .drop_cnt    (drop_cnt)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    int n;
    n = m_q.size();
    chk("count", 32'(count), 32'(n));
    chk("empty", 32'(empty), 32'(n == 0));
    chk("full", 32'(full), 32'(n == Depth));
    chk("almost_full", 32'(almost_full), 32'(n >= Depth - Margin));
    chk("rx_cts_ok", 32'(rx_cts_ok), 32'(n < Depth - Margin));
    chk("overflow", 32'(overflow), 32'(m_ovf));
    chk("drop_cnt", 32'(drop_cnt), 32'(m_drop));
    if (n != 0) chk("rd_data", 32'(rd_data), 32'(m_q[0]));
  endtask

  // Apply the current inputs to the model, then advance the DUT one edge and compare.
  task automatic tick();
    bit w;
    bit r;
    bit was_full;
    bit dropped;
    if (sys_rst) begin
      m_q.delete();
      m_prev = 1'b1;
      m_ovf  = 1'b0;
      m_drop = 0;
    end else begin
      w        = rx_ready && !m_prev;
      r        = rd_en && (m_q.size() != 0);
      was_full = (m_q.size() == Depth);
      dropped  = 1'b0;
      if (r) void'(m_q.pop_front());
      if (w) begin
        if (!was_full || r) m_q.push_back(rx_data);
        else dropped = 1'b1;
      end
      if (dropped) begin
        m_ovf = 1'b1;
        if (m_drop < 255) m_drop++;
      end else if (clr_overflow) begin
        m_ovf = 1'b0;
      end
      m_prev = rx_ready;
    end
    @(posedge sys_clk);
    #1;
    check_all();
  endtask

  task automatic wr_byte(input logic [7:0] d);
    rx_ready = 1'b0;
    tick();
    rx_data  = d;
    rx_ready = 1'b1;
    tick();
  endtask

  task automatic pop_all();
    rx_ready = 1'b0;
    rd_en    = 1'b1;
    for (int i = 0; i < Depth + 2; i++) tick();
    rd_en = 1'b0;
  endtask

  initial begin
    sys_rst      = 1'b1;
    rx_ready     = 1'b0;
    rd_en        = 1'b0;
    clr_overflow = 1'b0;
    rx_data      = 8'h00;
    tick();
    tick();
    chk("reset_count", 32'(count), 32'd0);
    chk("reset_cts", 32'(rx_cts_ok), 32'd1);
    sys_rst = 1'b0;
    tick();

    // Long ready pulse writes exactly once.
    rx_data  = 8'hA5;
    rx_ready = 1'b1;
    for (int i = 0; i < 40; i++) tick();
    chk("long_pulse_count", 32'(count), 32'd1);
    chk("long_pulse_data", 32'(rd_data), 32'hA5);
    pop_all();

    // Ready held across reset release is discarded.
    rx_ready = 1'b1;
    sys_rst  = 1'b1;
    tick();
    sys_rst = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    chk("held_ready_count", 32'(count), 32'd0);
    wr_byte(8'h3C);
    tick();
    chk("after_release_data", 32'(rd_data), 32'h3C);
    pop_all();

    // Fill, then overflow by one.
    for (int i = 0; i < Depth; i++) wr_byte(8'(i));
    tick();
    chk("fill_full", 32'(full), 32'd1);
    wr_byte(8'hFF);
    tick();
    chk("ovf_flag", 32'(overflow), 32'd1);
    chk("ovf_drop", 32'(drop_cnt), 32'd1);
    pop_all();

    // Clear overflow, refill, then write coincident with a pop at full.
    clr_overflow = 1'b1;
    tick();
    clr_overflow = 1'b0;
    for (int i = 0; i < Depth; i++) wr_byte(8'(8'h40 + i));
    rx_ready = 1'b0;
    tick();
    rx_data  = 8'h77;
    rx_ready = 1'b1;
    rd_en    = 1'b1;
    tick();
    rd_en = 1'b0;
    tick();
    chk("full_rw_count", 32'(count), 32'd16);
    chk("full_rw_ovf", 32'(overflow), 32'd0);
    pop_all();

    // Saturate drop counter.
    for (int i = 0; i < Depth; i++) wr_byte(8'(8'h80 + i));
    for (int i = 0; i < 300; i++) wr_byte(8'(i));
    chk("drop_sat", 32'(drop_cnt), 32'd255);
    rx_ready = 1'b0;
    tick();
    rx_ready     = 1'b1;
    clr_overflow = 1'b1;
    tick();
    clr_overflow = 1'b0;
    chk("drop_beats_clear", 32'(overflow), 32'd1);
    clr_overflow = 1'b1;
    tick();
    clr_overflow = 1'b0;
    chk("clear_alone", 32'(overflow), 32'd0);
    pop_all();

    // Reads on empty do nothing; next write follows wrapped pointers.
    rd_en = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    rd_en = 1'b0;
    chk("empty_rd_count", 32'(count), 32'd0);
    wr_byte(8'h5A);
    tick();
    chk("wrap_data", 32'(rd_data), 32'h5A);
    pop_all();

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 2) == 0) rx_ready = ~rx_ready;
      if (!rx_ready) rx_data = 8'($urandom);
      rd_en        = (i < 1500) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      clr_overflow = ($urandom_range(0, 15) == 0);
      sys_rst      = ($urandom_range(0, 399) == 0);
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
